conv_layer_sequencer: RTL and testbench
=======================================

// Module: conv_layer_sequencer
// PURPOSE
//  Parametrised two-layer convolution sequencer for the LeNet-5 accelerator datapath.
//  Drives the weight/bias ROM read addresses, the inter-layer feature buffer write/read
//  addresses, and the PE input strobes: one layer-1 pass, then L2_CH layer-2 channel passes.
//  Adds explicit start/busy/done/abort, per-channel weight reload and a registered read-latency pipe.
// PARAMETERS
//  K        3   kernel side; K*K weight words loaded per pass
//  L2_CH    16  layer-2 output channels (one pass each)
//  MAX_FMAP 24  maximum feature-map side held in the buffer
//  BUF_AW   10  buffer address width; 2**BUF_AW >= MAX_FMAP*MAX_FMAP
//  W_AW     8   weight ROM address width; 2**W_AW >= K*K*(1+L2_CH)
//  B_AW     5   bias ROM address width; 2**B_AW >= 1+L2_CH
// PORTS
//  clk          in  1       system clock, rising edge
//  rst_n        in  1       asynchronous active-low reset
//  start        in  1       1-cycle pulse, accepted only in IDLE
//  abort        in  1       synchronous abort; returns to IDLE next cycle
//  fmap_size    in  5       side of layer-1 output / layer-2 input, sampled at start
//  din_valid    in  1       external layer-1 pixel valid
//  l1_dout_valid in 1       layer-1 PE result valid (one buffer word per cycle)
//  l2_pass_done in  1       1-cycle pulse: layer-2 PE flushed current channel
//  busy         out 1       high from accepted start until done/abort
//  done         out 1       1-cycle pulse at end of last layer-2 pass
//  layer_sel    out 1       0 = layer 1, 1 = layer 2
//  ch_idx       out 5       current layer-2 channel, 0..L2_CH-1
//  win_load     out 1       weight-window load strobe to PE
//  rom_w_raddr  out W_AW    weight ROM read address
//  rom_b_raddr  out B_AW    bias ROM read address
//  buf_we       out 1       buffer write enable
//  buf_waddr    out BUF_AW  buffer write address
//  buf_re       out 1       buffer read enable
//  buf_raddr    out BUF_AW  buffer read address
//  pe_din_valid out 1       PE input valid (din_valid in L1, buf_re delayed 1 cycle in L2)
//  perf_cycles  out 32      busy-cycle counter (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state IDLE; every output and counter 0.
//  npix = fmap_size*fmap_size, computed at 10 bits and registered at start.
//  fmap_size of 0 or greater than MAX_FMAP: done pulses 1 cycle after start; no strobes.
//  FSM: IDLE -> L1_WLOAD -> L1_RUN -> L2_WLOAD -> L2_STREAM -> L2_WAIT
//       -> (L2_WLOAD with ch+1 | DONE) -> IDLE.
//  *_WLOAD: win_load high for exactly K*K cycles.
//   rom_w_raddr = base + k, where base = 0 for L1 and K*K*(1+ch) for L2.
//   rom_b_raddr = 0 for L1 and 1+ch for L2, held for the whole pass.
//  L1_RUN: pe_din_valid = din_valid.
//   buf_we = l1_dout_valid registered once; buf_waddr increments per write from 0.
//   Exit to L2_WLOAD (ch=0) the cycle after write npix-1; further l1_dout_valid is ignored.
//  L2_STREAM: buf_re high for npix consecutive cycles, buf_raddr 0..npix-1.
//   pe_din_valid = buf_re delayed 1 cycle (registered read latency).
//   Exit to L2_WAIT after raddr npix-1.
//  L2_WAIT: hold until l2_pass_done, then ch+1. Exit to DONE when ch==L2_CH-1.
//   l2_pass_done outside L2_WAIT is ignored.
//  DONE: done=1 for one cycle, busy drops in the same cycle as done.
//  start while busy: ignored. abort and start in the same cycle: abort wins.
//  abort: all strobes low next cycle, counters cleared, no done pulse.
//  Reset mid-operation: identical to power-up reset.
//  Address counters never wrap. Terminal compare is ==npix-1 at BUF_AW bits.
// CONFIGURATION
//  SEQ_PERF_CNT_EN defined: perf_cycles counts cycles with busy=1, cleared on an
//   accepted start, saturates at 32'hFFFF_FFFF, holds after done.
//  SEQ_PERF_CNT_EN undefined: perf_cycles tied to 0; no counter logic.
// STRUCTURE
//  Package conv_seq_pkg: FSM state encoding localparams, K*K and bias base constants.
//  One sub-module, seq_addr_counter: load/enable/terminal-flag counter, instanced for
//   weight k, buffer write address and buffer read address.
// TESTING
//  1. fmap_size=10, K=3, L2_CH=2, 100 l1_dout_valid, 2 l2_pass_done
//     -> 9 win_load per pass; buf_waddr 0..99; 2x buf_raddr 0..99; single done.
//  2. L2 ch=1 pass -> rom_w_raddr 18..26 and rom_b_raddr=2 for that pass.
//  3. fmap_size=0 -> done pulse 1 cycle after start; win_load/buf_we/buf_re never high.
//  4. abort mid-L2_STREAM at raddr=37 -> next cycle IDLE, buf_re=0, busy=0, no done;
//     a following start runs clean from ch=0.
//  5. start pulsed during L2_WAIT and l2_pass_done pulsed during L2_STREAM
//     -> both ignored; sequence and counts unchanged.
//  6. With SEQ_PERF_CNT_EN, test 1 -> perf_cycles equals measured busy cycles.
//     Without it -> perf_cycles stays 0.

Source files
------------

// File: rtl/conv_seq_pkg.sv
// Shared FSM encoding and ROM address-map helpers for the two-layer convolution sequencer.
package conv_seq_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StL1Wload,
      StL1Run,
      StL2Wload,
      StL2Stream,
      StL2Wait,
      StDone
   } seq_state_e;

   // fmap_size * fmap_size is formed at this width before truncation to the buffer width.
   localparam int unsigned NpixW      = 10;
   localparam int unsigned L1BiasAddr = 0;

   function automatic int unsigned win_words(input int unsigned k);
      return k * k;
   endfunction

   // Layer 1 owns weight window 0; layer-2 channel c owns window 1+c.
   function automatic int unsigned w_base(input int unsigned k, input int unsigned ch,
                                          input logic l2);
      return l2 ? win_words(k) * (ch + 1) : 0;
   endfunction

   function automatic int unsigned b_addr(input int unsigned ch, input logic l2);
      return l2 ? ch + 1 : L1BiasAddr;
   endfunction

endpackage

// File: rtl/seq_addr_counter.sv
// Clearable up-counter with terminal flag; holds at the terminal value instead of wrapping.
module seq_addr_counter #(
   parameter int unsigned Width = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic [Width-1:0] last_i,
   output logic [Width-1:0] cnt_o,
   output logic             last_o
);

   logic [Width-1:0] cnt_d, cnt_q;

   assign last_o = (cnt_q == last_i);
   assign cnt_o  = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && !last_o) begin
         cnt_d = cnt_q + Width'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/conv_layer_sequencer.sv
// Two-layer convolution sequencer: weight/bias ROM addressing, feature-buffer traffic, PE strobes.
// Optional busy-cycle counter enabled by defining SEQ_PERF_CNT_EN.
module conv_layer_sequencer
   import conv_seq_pkg::*;
#(
   parameter int unsigned K        = 3,
   parameter int unsigned L2_CH    = 16,
   parameter int unsigned MAX_FMAP = 24,
   parameter int unsigned BUF_AW   = 10,
   parameter int unsigned W_AW     = 8,
   parameter int unsigned B_AW     = 5
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic              abort_i,
   input  logic [4:0]        fmap_size_i,
   input  logic              din_valid_i,
   input  logic              l1_dout_valid_i,
   input  logic              l2_pass_done_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              layer_sel_o,
   output logic [4:0]        ch_idx_o,
   output logic              win_load_o,
   output logic [W_AW-1:0]   rom_w_raddr_o,
   output logic [B_AW-1:0]   rom_b_raddr_o,
   output logic              buf_we_o,
   output logic [BUF_AW-1:0] buf_waddr_o,
   output logic              buf_re_o,
   output logic [BUF_AW-1:0] buf_raddr_o,
   output logic              pe_din_valid_o,
   output logic [31:0]       perf_cycles_o
);

   localparam int unsigned KK = win_words(K);

   seq_state_e        state_q, state_d;
   logic [4:0]        ch_q, ch_d;
   logic [BUF_AW-1:0] npix_m1_q, npix_m1_d;
   logic              we_q, we_d;
   logic              re_q, re_d;

   logic [NpixW-1:0]  npix_calc;
   logic              fmap_ok;

   logic              k_clr, k_en, k_last;
   logic [W_AW-1:0]   k_cnt;
   logic              w_clr, w_last;
   logic [BUF_AW-1:0] w_cnt;
   logic              r_clr, r_en, r_last;
   logic [BUF_AW-1:0] r_cnt;

   assign npix_calc = NpixW'(fmap_size_i) * NpixW'(fmap_size_i);
   assign fmap_ok   = (fmap_size_i != '0) && (32'(fmap_size_i) <= MAX_FMAP);

   seq_addr_counter #(.Width(W_AW)) u_k_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (k_clr),
      .en_i   (k_en),
      .last_i (W_AW'(KK - 1)),
      .cnt_o  (k_cnt),
      .last_o (k_last)
   );

   seq_addr_counter #(.Width(BUF_AW)) u_waddr_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (w_clr),
      .en_i   (we_q),
      .last_i (npix_m1_q),
      .cnt_o  (w_cnt),
      .last_o (w_last)
   );

   seq_addr_counter #(.Width(BUF_AW)) u_raddr_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (r_clr),
      .en_i   (r_en),
      .last_i (npix_m1_q),
      .cnt_o  (r_cnt),
      .last_o (r_last)
   );

   always_comb begin
      state_d   = state_q;
      ch_d      = ch_q;
      npix_m1_d = npix_m1_q;
      we_d      = 1'b0;
      k_clr     = 1'b0;
      k_en      = 1'b0;
      w_clr     = 1'b0;
      r_clr     = 1'b0;
      r_en      = 1'b0;
      if (abort_i) begin
         state_d = StIdle;
         ch_d    = '0;
         k_clr   = 1'b1;
         w_clr   = 1'b1;
         r_clr   = 1'b1;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start_i) begin
                  ch_d      = '0;
                  k_clr     = 1'b1;
                  w_clr     = 1'b1;
                  r_clr     = 1'b1;
                  npix_m1_d = BUF_AW'(npix_calc - NpixW'(1));
                  state_d   = fmap_ok ? StL1Wload : StDone;
               end
            end
            StL1Wload: begin
               k_en = 1'b1;
               if (k_last) begin
                  k_clr   = 1'b1;
                  state_d = StL1Run;
               end
            end
            StL1Run: begin
               // The registered write of word npix-1 ends the layer; later valids are dropped.
               if (we_q && w_last) begin
                  w_clr   = 1'b1;
                  ch_d    = '0;
                  state_d = StL2Wload;
               end else begin
                  we_d = l1_dout_valid_i;
               end
            end
            StL2Wload: begin
               k_en = 1'b1;
               if (k_last) begin
                  k_clr   = 1'b1;
                  state_d = StL2Stream;
               end
            end
            StL2Stream: begin
               r_en = 1'b1;
               if (r_last) begin
                  r_clr   = 1'b1;
                  state_d = StL2Wait;
               end
            end
            StL2Wait: begin
               if (l2_pass_done_i) begin
                  if (ch_q == 5'(L2_CH - 1)) begin
                     state_d = StDone;
                  end else begin
                     ch_d    = ch_q + 5'd1;
                     state_d = StL2Wload;
                  end
               end
            end
            StDone: begin
               ch_d    = '0;
               state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // Buffer read data arrives one cycle after buf_re, so the PE strobe is the delayed enable.
   assign re_d = !abort_i && (state_q == StL2Stream);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= StIdle;
         ch_q      <= '0;
         npix_m1_q <= '0;
         we_q      <= 1'b0;
         re_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         ch_q      <= ch_d;
         npix_m1_q <= npix_m1_d;
         we_q      <= we_d;
         re_q      <= re_d;
      end
   end

   assign busy_o         = !(state_q inside {StIdle, StDone});
   assign done_o         = (state_q == StDone);
   assign layer_sel_o    = state_q inside {StL2Wload, StL2Stream, StL2Wait};
   assign ch_idx_o       = ch_q;
   assign win_load_o     = (state_q == StL1Wload) || (state_q == StL2Wload);
   assign rom_w_raddr_o  = win_load_o ? W_AW'(w_base(K, 32'(ch_q), layer_sel_o)) + k_cnt : '0;
   assign rom_b_raddr_o  = B_AW'(b_addr(32'(ch_q), layer_sel_o));
   assign buf_we_o       = we_q;
   assign buf_waddr_o    = w_cnt;
   assign buf_re_o       = (state_q == StL2Stream);
   assign buf_raddr_o    = r_cnt;
   assign pe_din_valid_o = (state_q == StL1Run) ? din_valid_i : re_q;

`ifdef SEQ_PERF_CNT_EN
   logic [31:0] perf_q, perf_d;

   always_comb begin
      perf_d = perf_q;
      if ((state_q == StIdle) && start_i && !abort_i) begin
         perf_d = '0;
      end else if (busy_o && (perf_q != 32'hFFFF_FFFF)) begin
         perf_d = perf_q + 32'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         perf_q <= '0;
      end else begin
         perf_q <= perf_d;
      end
   end

   assign perf_cycles_o = perf_q;
`else
   assign perf_cycles_o = '0;
`endif

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Scoreboard bench for conv_layer_sequencer (K=3, L2_CH=2): queued expected addresses vs strobes.
module tb_conv_layer_sequencer;

   localparam int unsigned K      = 3;
   localparam int unsigned L2_CH  = 2;
   localparam int unsigned KK     = K * K;
   localparam int unsigned BUF_AW = 10;
   localparam int unsigned W_AW   = 8;
   localparam int unsigned B_AW   = 5;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start, abort, din_valid, l1_dout_valid, l2_pass_done;
   logic [4:0]        fmap_size;
   logic              busy, done, layer_sel, win_load, buf_we, buf_re, pe_din_valid;
   logic [4:0]        ch_idx;
   logic [W_AW-1:0]   rom_w_raddr;
   logic [B_AW-1:0]   rom_b_raddr;
   logic [BUF_AW-1:0] buf_waddr, buf_raddr;
   logic [31:0]       perf_cycles;

   int total = 0;
   int bad = 0;
   int done_cnt = 0;
   int busy_cnt = 0;
   logic prev_re = 1'b0;
   int q_w[$], q_b[$], q_ch[$], q_wr[$], q_rd[$];
   int e_w, e_b, e_ch, e_wr, e_rd;

   always #5 clk = ~clk;

   conv_layer_sequencer #(
      .K(K), .L2_CH(L2_CH), .MAX_FMAP(24), .BUF_AW(BUF_AW), .W_AW(W_AW), .B_AW(B_AW)
   ) dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .start_i         (start),
      .abort_i         (abort),
      .fmap_size_i     (fmap_size),
      .din_valid_i     (din_valid),
      .l1_dout_valid_i (l1_dout_valid),
      .l2_pass_done_i  (l2_pass_done),
      .busy_o          (busy),
      .done_o          (done),
      .layer_sel_o     (layer_sel),
      .ch_idx_o        (ch_idx),
      .win_load_o      (win_load),
      .rom_w_raddr_o   (rom_w_raddr),
      .rom_b_raddr_o   (rom_b_raddr),
      .buf_we_o        (buf_we),
      .buf_waddr_o     (buf_waddr),
      .buf_re_o        (buf_re),
      .buf_raddr_o     (buf_raddr),
      .pe_din_valid_o  (pe_din_valid),
      .perf_cycles_o   (perf_cycles)
   );

   function automatic void check(input string tag, input logic [63:0] obs,
                                 input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endfunction

   // Monitor: every strobe pops its expected value; an empty queue yields -1 and cannot match.
   always @(negedge clk) begin
      if (rst_n) begin
         if (win_load) begin
            e_w  = (q_w.size() != 0) ? q_w.pop_front() : -1;
            e_b  = (q_b.size() != 0) ? q_b.pop_front() : -1;
            e_ch = (q_ch.size() != 0) ? q_ch.pop_front() : -1;
            check("rom_w_raddr", 64'(rom_w_raddr), 64'(e_w));
            check("rom_b_raddr", 64'(rom_b_raddr), 64'(e_b));
            check("ch_idx", 64'(ch_idx), 64'(e_ch));
         end
         if (buf_we) begin
            e_wr = (q_wr.size() != 0) ? q_wr.pop_front() : -1;
            check("buf_waddr", 64'(buf_waddr), 64'(e_wr));
         end
         if (buf_re) begin
            e_rd = (q_rd.size() != 0) ? q_rd.pop_front() : -1;
            check("buf_raddr", 64'(buf_raddr), 64'(e_rd));
         end
         if (busy && !layer_sel && !win_load) check("pe_din_l1", 64'(pe_din_valid), 64'(din_valid));
         if (layer_sel) check("pe_din_l2", 64'(pe_din_valid), 64'(prev_re));
         if (done) begin
            done_cnt++;
            check("done_busy_low", 64'(busy), 64'd0);
         end
         if (busy) busy_cnt++;
      end
      prev_re = buf_re;
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_pass(input int p);
      for (int k = 0; k < int'(KK); k++) begin
         q_w.push_back(p * int'(KK) + k);
         q_b.push_back(p);
         q_ch.push_back((p == 0) ? 0 : p - 1);
      end
   endtask

   task automatic feed_l1();
      int n = 0;
      while (!layer_sel && n < 4000) begin
         l1_dout_valid = ($urandom_range(0, 3) != 0);
         din_valid     = $urandom_range(0, 1) != 0;
         tick();
         n++;
      end
      l1_dout_valid = 1'b0;
      din_valid     = 1'b0;
      check("l1_reaches_l2", 64'(layer_sel), 64'd1);
   endtask

   task automatic stream_pass(input bit inj);
      int n = 0;
      while (!buf_re && n < 200) begin
         tick();
         n++;
      end
      check("stream_starts", 64'(buf_re), 64'd1);
      n = 0;
      while (buf_re && n < 2000) begin
         l2_pass_done = inj && (n == 4);
         tick();
         n++;
      end
      l2_pass_done = 1'b0;
      check("stream_ends", 64'(buf_re), 64'd0);
      tick();
      tick();
      if (inj) begin
         start = 1'b1;
         tick();
         start = 1'b0;
      end
      tick();
      l2_pass_done = 1'b1;
      tick();
      l2_pass_done = 1'b0;
   endtask

   task automatic check_perf(input string tag);
`ifdef SEQ_PERF_CNT_EN
      check(tag, 64'(perf_cycles), 64'(busy_cnt));
`else
      check(tag, 64'(perf_cycles), 64'd0);
`endif
   endtask

   task automatic run_full(input int fmap, input bit inj);
      int npix = fmap * fmap;
      int d0 = done_cnt;
      int n = 0;
      for (int p = 0; p <= int'(L2_CH); p++) push_pass(p);
      for (int i = 0; i < npix; i++) q_wr.push_back(i);
      for (int c = 0; c < int'(L2_CH); c++)
         for (int i = 0; i < npix; i++) q_rd.push_back(i);
      busy_cnt  = 0;
      fmap_size = 5'(fmap);
      start     = 1'b1;
      tick();
      start = 1'b0;
      feed_l1();
      for (int c = 0; c < int'(L2_CH); c++) stream_pass(inj);
      while (busy && n < 50) begin
         tick();
         n++;
      end
      tick();
      tick();
      check("done_once", 64'(done_cnt - d0), 64'd1);
      check("win_left", 64'(q_w.size()), 64'd0);
      check("wr_left", 64'(q_wr.size()), 64'd0);
      check("rd_left", 64'(q_rd.size()), 64'd0);
      check_perf("perf_cycles");
      repeat (3) tick();
      check_perf("perf_hold");
      check("idle_busy", 64'(busy), 64'd0);
   endtask

   task automatic bad_fmap(input int fmap);
      int d0 = done_cnt;
      fmap_size = 5'(fmap);
      start     = 1'b1;
      tick();
      start = 1'b0;
      check("bad_fmap_done", 64'(done), 64'd1);
      check("bad_fmap_busy", 64'(busy), 64'd0);
      tick();
      check("bad_fmap_done_width", 64'(done), 64'd0);
      tick();
      check("bad_fmap_done_cnt", 64'(done_cnt - d0), 64'd1);
   endtask

   initial begin
      int n;
      int d0;
      rst_n = 1'b0;
      {start, abort, din_valid, l1_dout_valid, l2_pass_done} = '0;
      fmap_size = 5'd0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", 64'({busy, done, layer_sel, ch_idx, win_load, rom_w_raddr,
                                  rom_b_raddr, buf_we, buf_waddr, buf_re, buf_raddr,
                                  pe_din_valid}), 64'd0);
      check("reset_perf", 64'(perf_cycles), 64'd0);
      rst_n = 1'b1;
      tick();

      run_full(10, 1'b0);
      bad_fmap(0);
      bad_fmap(25);

      // Abort in the middle of the first layer-2 stream.
      d0 = done_cnt;
      push_pass(0);
      for (int i = 0; i < 100; i++) q_wr.push_back(i);
      push_pass(1);
      for (int i = 0; i <= 37; i++) q_rd.push_back(i);
      fmap_size = 5'd10;
      start     = 1'b1;
      tick();
      start = 1'b0;
      feed_l1();
      n = 0;
      while (!(buf_re && buf_raddr == 10'd37) && n < 200) begin
         tick();
         n++;
      end
      check("abort_point", 64'(buf_raddr), 64'd37);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_buf_re", 64'(buf_re), 64'd0);
      check("abort_strobes", 64'({win_load, layer_sel, buf_we, pe_din_valid}), 64'd0);
      check("abort_ch", 64'(ch_idx), 64'd0);
      repeat (3) tick();
      check("abort_no_done", 64'(done_cnt - d0), 64'd0);
      check("abort_rd_left", 64'(q_rd.size()), 64'd0);
      check("abort_wr_left", 64'(q_wr.size()), 64'd0);
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      check("abort_beats_start", 64'(busy), 64'd0);
      tick();
      check("abort_start_no_done", 64'(done_cnt - d0), 64'd0);
      run_full(10, 1'b0);

      run_full(10, 1'b1);
      run_full(1, 1'b0);
      run_full(24, 1'b0);

      // Reset in the middle of the layer-1 weight load.
      push_pass(0);
      fmap_size = 5'd10;
      start     = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      rst_n = 1'b0;
      #2;
      check("midreset_outputs", 64'({busy, done, layer_sel, ch_idx, win_load, rom_w_raddr,
                                     rom_b_raddr, buf_we, buf_waddr, buf_re, buf_raddr,
                                     pe_din_valid}), 64'd0);
      check("midreset_perf", 64'(perf_cycles), 64'd0);
      tick();
      rst_n = 1'b1;
      q_w.delete();
      q_b.delete();
      q_ch.delete();
      tick();
      run_full(4, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
